// File: rtl/ysyx_25030085_idu_issue.sv
// rtl/ysyx_25030085_idu_issue.sv - RV32I registered decode/issue stage with valid/ready handshake
module ysyx_25030085_idu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1_idx,
    output logic [4:0]      out_rs2_idx,
    output logic [4:0]      out_rd_idx,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_src,
    output logic            out_reg_wen,
    output logic            out_mem_ren,
    output logic            out_mem_wen,
    output logic [2:0]      out_funct3,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_ebreak,
    output logic            out_illegal
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_PCB  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Shared funct3 -> ALU mapping for OP and OP-IMM; alt selects sub/sra
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_sh;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rd_field = in_inst[11:7];
    assign imm_i    = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b    = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u    = {in_inst[31:12], 12'b0};
    assign imm_j    = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_sh   = {27'b0, in_inst[24:20]};

    logic            legal;
    logic            wr_class;
    logic            rs1_zero;
    logic [3:0]      d_alu_op;
    logic            d_alu_src;
    logic [XLEN-1:0] d_imm;
    logic            d_reg_wen;
    logic            d_mem_ren;
    logic            d_mem_wen;
    logic            d_branch;
    logic            d_jal;
    logic            d_jalr;
    logic            d_ebreak;
    logic [4:0]      d_rs1;

    // Decode the incoming word; illegal encodings clear every control enable
    always_comb begin
        legal     = 1'b0;
        wr_class  = 1'b0;
        rs1_zero  = 1'b0;
        d_alu_op  = ALU_ADD;
        d_alu_src = 1'b0;
        d_imm     = '0;
        d_mem_ren = 1'b0;
        d_mem_wen = 1'b0;
        d_branch  = 1'b0;
        d_jal     = 1'b0;
        d_jalr    = 1'b0;
        d_ebreak  = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal    = (funct7 == F7_ZERO) ||
                           ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                wr_class = 1'b1;
                d_alu_op = arith_op(funct3, in_inst[30]);
            end
            OPC_OP_IMM: begin
                wr_class  = 1'b1;
                d_alu_src = 1'b1;
                if (funct3 == 3'b001) begin
                    legal = (funct7 == F7_ZERO);
                    d_imm = imm_sh;
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    d_imm = imm_sh;
                end else begin
                    legal = 1'b1;
                    d_imm = imm_i;
                end
                // bit30 is part of the immediate for addi, so only shifts look at it
                d_alu_op = arith_op(funct3, (funct3 == 3'b101) && in_inst[30]);
            end
            OPC_LUI: begin
                legal     = 1'b1;
                wr_class  = 1'b1;
                rs1_zero  = 1'b1;
                d_alu_src = 1'b1;
                d_imm     = imm_u;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                wr_class  = 1'b1;
                d_alu_op  = ALU_PCB;
                d_alu_src = 1'b1;
                d_imm     = imm_u;
            end
            OPC_JAL: begin
                legal     = 1'b1;
                wr_class  = 1'b1;
                d_jal     = 1'b1;
                d_alu_op  = ALU_PCB;
                d_alu_src = 1'b1;
                d_imm     = imm_j;
            end
            OPC_JALR: begin
                legal     = (funct3 == 3'b000);
                wr_class  = 1'b1;
                d_jalr    = 1'b1;
                d_alu_src = 1'b1;
                d_imm     = imm_i;
            end
            OPC_BRANCH: begin
                legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
                d_branch  = 1'b1;
                d_alu_op  = ALU_PCB;
                d_alu_src = 1'b1;
                d_imm     = imm_b;
            end
            OPC_LOAD: begin
                legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                wr_class  = 1'b1;
                d_mem_ren = 1'b1;
                d_alu_src = 1'b1;
                d_imm     = imm_i;
            end
            OPC_STORE: begin
                legal     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                d_mem_wen = 1'b1;
                d_alu_src = 1'b1;
                d_imm     = imm_s;
            end
            OPC_SYSTEM: begin
                legal    = (in_inst == 32'h0010_0073);
                d_ebreak = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            wr_class  = 1'b0;
            d_alu_op  = ALU_ADD;
            d_alu_src = 1'b0;
            d_imm     = '0;
            d_mem_ren = 1'b0;
            d_mem_wen = 1'b0;
            d_branch  = 1'b0;
            d_jal     = 1'b0;
            d_jalr    = 1'b0;
            d_ebreak  = 1'b0;
        end
        d_reg_wen = wr_class && (rd_field != 5'd0);
        d_rs1     = rs1_zero ? 5'd0 : in_inst[19:15];
    end

    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Pipeline register: reset over flush over accept over drain; hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1_idx <= '0;
            out_rs2_idx <= '0;
            out_rd_idx  <= '0;
            out_imm     <= '0;
            out_alu_op  <= '0;
            out_alu_src <= 1'b0;
            out_reg_wen <= 1'b0;
            out_mem_ren <= 1'b0;
            out_mem_wen <= 1'b0;
            out_funct3  <= '0;
            out_branch  <= 1'b0;
            out_jal     <= 1'b0;
            out_jalr    <= 1'b0;
            out_ebreak  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rs1_idx <= d_rs1;
            out_rs2_idx <= in_inst[24:20];
            out_rd_idx  <= rd_field;
            out_imm     <= d_imm;
            out_alu_op  <= d_alu_op;
            out_alu_src <= d_alu_src;
            out_reg_wen <= d_reg_wen;
            out_mem_ren <= d_mem_ren;
            out_mem_wen <= d_mem_wen;
            out_funct3  <= funct3;
            out_branch  <= d_branch;
            out_jal     <= d_jal;
            out_jalr    <= d_jalr;
            out_ebreak  <= d_ebreak;
            out_illegal <= !legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_25030085_idu_issue.sv
// tb/tb_ysyx_25030085_idu_issue.sv - randomized scoreboard bench for the decode/issue stage
module tb_ysyx_25030085_idu_issue;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        ebreak;
        logic        illegal;
    } bundle_t;

    // ALU codes for funct3 0..7 (add sll slt sltu xor srl or and), one hex digit each
    localparam logic [31:0] ARITH_TAB = 32'h8764_3210;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1_idx;
    logic [4:0]  out_rs2_idx;
    logic [4:0]  out_rd_idx;
    logic [31:0] out_imm;
    logic [3:0]  out_alu_op;
    logic        out_alu_src;
    logic        out_reg_wen;
    logic        out_mem_ren;
    logic        out_mem_wen;
    logic [2:0]  out_funct3;
    logic        out_branch;
    logic        out_jal;
    logic        out_jalr;
    logic        out_ebreak;
    logic        out_illegal;

    bundle_t dut_b;
    bundle_t zero_b;
    bundle_t q[$];
    int      checks = 0;
    int      errors = 0;
    int      delivered = 0;

    ysyx_25030085_idu_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_idx(out_rs1_idx), .out_rs2_idx(out_rs2_idx), .out_rd_idx(out_rd_idx),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_reg_wen(out_reg_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
        .out_funct3(out_funct3), .out_branch(out_branch), .out_jal(out_jal),
        .out_jalr(out_jalr), .out_ebreak(out_ebreak), .out_illegal(out_illegal)
    );

    assign dut_b = {out_pc, out_rs1_idx, out_rs2_idx, out_rd_idx, out_imm, out_alu_op,
                    out_alu_src, out_reg_wen, out_mem_ren, out_mem_wen, out_funct3,
                    out_branch, out_jal, out_jalr, out_ebreak, out_illegal};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input int v, input int n);
        return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
    endfunction

    // Reference decode written straight from the instruction-class rules
    function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        bundle_t    b;
        logic [6:0] op;
        logic [6:0] f7;
        int         f3;
        bit         ok;
        bit         wr;
        b        = '0;
        op       = inst[6:0];
        f7       = inst[31:25];
        f3       = int'(inst[14:12]);
        b.pc     = pc;
        b.rs1    = inst[19:15];
        b.rs2    = inst[24:20];
        b.rd     = inst[11:7];
        b.funct3 = inst[14:12];
        ok       = 0;
        wr       = 0;
        case (op)
            7'h33: begin
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                wr = 1;
                if (f7 == 0) b.alu_op = ARITH_TAB[f3*4 +: 4];
                else         b.alu_op = (f3 == 0) ? 4'hA : 4'h5;
            end
            7'h13: begin
                wr = 1;
                b.alu_src = 1;
                b.alu_op = ARITH_TAB[f3*4 +: 4];
                if (f3 == 1 || f3 == 5) begin
                    b.imm = 32'(inst[24:20]);
                    ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
                    if (f3 == 5 && f7 == 7'h20) b.alu_op = 4'h5;
                end else begin
                    b.imm = sext(int'(inst[31:20]), 12);
                    ok = 1;
                end
            end
            7'h37: begin
                ok = 1; wr = 1; b.alu_src = 1; b.rs1 = 0;
                b.imm = {inst[31:12], 12'h000};
            end
            7'h17: begin
                ok = 1; wr = 1; b.alu_src = 1; b.alu_op = 4'h9;
                b.imm = {inst[31:12], 12'h000};
            end
            7'h6F: begin
                ok = 1; wr = 1; b.jal = 1; b.alu_src = 1; b.alu_op = 4'h9;
                b.imm = sext(int'({inst[31], inst[19:12], inst[20], inst[30:21]}), 20) * 2;
            end
            7'h67: begin
                ok = (f3 == 0); wr = 1; b.jalr = 1; b.alu_src = 1;
                b.imm = sext(int'(inst[31:20]), 12);
            end
            7'h63: begin
                ok = !(f3 == 2 || f3 == 3); b.branch = 1; b.alu_src = 1; b.alu_op = 4'h9;
                b.imm = sext(int'({inst[31], inst[7], inst[30:25], inst[11:8]}), 12) * 2;
            end
            7'h03: begin
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                wr = 1; b.mem_ren = 1; b.alu_src = 1;
                b.imm = sext(int'(inst[31:20]), 12);
            end
            7'h23: begin
                ok = (f3 <= 2); b.mem_wen = 1; b.alu_src = 1;
                b.imm = sext(int'({inst[31:25], inst[11:7]}), 12);
            end
            7'h73: begin
                ok = (inst == 32'h0010_0073); b.ebreak = 1;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            wr = 0; b.alu_op = 0; b.alu_src = 0; b.imm = 0;
            b.mem_ren = 0; b.mem_wen = 0; b.branch = 0; b.jal = 0; b.jalr = 0; b.ebreak = 0;
            b.illegal = 1;
        end
        b.reg_wen = wr && (b.rd != 0);
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 13);
        case (k)
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h37;
            3:  w[6:0] = 7'h17;
            4:  w[6:0] = 7'h6F;
            5:  w[6:0] = 7'h67;
            6:  w[6:0] = 7'h63;
            7:  w[6:0] = 7'h03;
            8:  w[6:0] = 7'h23;
            9:  w[6:0] = 7'h73;
            10: w = 32'h0010_0073;
            11: begin w[6:0] = 7'h13; w[11:7] = 5'd0; end
            default: ;
        endcase
        if ((k == 0 || k == 1) && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ((k == 5 || k == 10) && $urandom_range(0, 1) != 0) w[14:12] = 3'b000;
        return w;
    endfunction

    // One clock: drive inputs at the falling edge, check outputs, advance the scoreboard
    task automatic cyc(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit r);
        bit exp_v;
        bit exp_rdy;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        exp_v   = (q.size() != 0);
        exp_rdy = !exp_v || ordy;
        check("out_valid", 128'(out_valid), 128'(exp_v));
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        if (exp_v) check("payload", 128'(dut_b), 128'(q[0]));
        if (out_valid && ordy) delivered++;
        if (r || fl) begin
            q.delete();
        end else begin
            if (ordy && exp_v) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(ref_decode(inst, pc));
        end
        @(negedge clk);
    endtask

    initial begin
        int d0;
        zero_b = '0;
        @(negedge clk);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_payload", 128'(dut_b), 128'(zero_b));
        check("rst_ready", 128'(in_ready), 128'(1));

        cyc(1, 32'h0050_0093, 32'h8000_0000, 1, 0, 0);
        check("addi_imm", 128'(out_imm), 128'(32'h5));
        check("addi_op", 128'(out_alu_op), 128'(4'h0));
        check("addi_src", 128'(out_alu_src), 128'(1));
        check("addi_wen", 128'(out_reg_wen), 128'(1));
        check("addi_rd", 128'(out_rd_idx), 128'(1));
        cyc(1, 32'h4030_D113, 32'h8000_0004, 1, 0, 0);
        check("srai_imm", 128'(out_imm), 128'(32'h3));
        check("srai_op", 128'(out_alu_op), 128'(4'h5));
        cyc(1, 32'h4020_81B3, 32'h8000_0008, 1, 0, 0);
        check("sub_op", 128'(out_alu_op), 128'(4'hA));
        check("sub_src", 128'(out_alu_src), 128'(0));
        check("sub_rs2", 128'(out_rs2_idx), 128'(2));
        cyc(1, 32'hFFFF_FFFF, 32'h8000_000C, 1, 0, 0);
        check("ill_flag", 128'(out_illegal), 128'(1));
        check("ill_wen", 128'(out_reg_wen), 128'(0));
        cyc(1, 32'h0000_0013, 32'h8000_0010, 1, 0, 0);
        check("x0_wen", 128'(out_reg_wen), 128'(0));
        cyc(1, 32'hFE00_0EE3, 32'h8000_0014, 1, 0, 0);
        check("beq_imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
        check("beq_br", 128'(out_branch), 128'(1));
        cyc(0, 0, 0, 1, 0, 0);

        d0 = delivered;
        cyc(1, 32'h0050_0093, 32'h100, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h4020_81B3, 32'h104, 0, 0, 0);
        cyc(1, 32'h4020_81B3, 32'h104, 1, 0, 0);
        check("bp_sub", 128'(out_alu_op), 128'(4'hA));
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("bp_count", 128'(delivered - d0), 128'(2));

        cyc(1, 32'h0050_0093, 32'h200, 1, 0, 0);
        cyc(1, 32'h0010_0073, 32'h204, 1, 1, 0);
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_ready", 128'(in_ready), 128'(1));
        cyc(0, 0, 0, 1, 0, 0);

        cyc(1, 32'h0050_0093, 32'h300, 1, 0, 0);
        cyc(1, 32'h4020_81B3, 32'h304, 0, 0, 1);
        check("rm_valid", 128'(out_valid), 128'(0));
        check("rm_payload", 128'(dut_b), 128'(zero_b));
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25030085_idu_issue.md
Name: ysyx_25030085_idu_issue

Overview:
- Registered decode/issue stage for the RV32I core. It turns a fetched instruction word into the control and operand-select bundle the ALU consumes: 4-bit ALU opcode, ALU B-source select, sign-extended immediate and register indices.
- Sits between IFU and EXU, with valid/ready handshakes on both sides.
- Single-entry pipeline register: supports back-pressure and flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the held instruction and any instruction accepted this cycle.
- in_valid  in  1  IFU presents an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts the bundle.
- out_pc  out  32  registered pc.
- out_rs1_idx, out_rs2_idx, out_rd_idx  out  5 each  register indices.
- out_imm  out  32  immediate.
- out_alu_op  out  4  ALU operation code.
- out_alu_src  out  1  0 = rs2, 1 = immediate.
- out_reg_wen  out  1  rd write enable; forced 0 when rd = x0.
- out_mem_ren, out_mem_wen  out  1 each  load / store.
- out_funct3  out  3  width/sign or branch condition.
- out_branch, out_jal, out_jalr, out_ebreak, out_illegal  out  1 each  class flags.

Behaviour:
- Reset (rst = 1 at a clock edge): out_valid = 0; all out_* payload = 0; in_ready = 1 the next cycle.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready. Decoded bundle is registered the same edge; out_valid = 1 the following cycle. Latency is 1 cycle.
- Throughput: 1 instruction/cycle with out_ready held high.
- Hold: out_valid && !out_ready → all out_* stable; no input consumed.
- Drain without refill: out_ready && !accept → out_valid <= 0; payload may hold stale values.
- Flush: has priority over accept and hold. out_valid <= 0 next edge; an input handshake in the flush cycle is consumed and discarded.
- rst has priority over flush.
- ALU opcode encoding:
  - 0000 add
  - 1010 sub
  - 0001 sll
  - 1001 pc+B
  - 0010 slt
  - 0011 sltu
  - 0101 sra
  - 0110 srl
  - 0100 xor
  - 0111 or
  - 1000 and
- OP (0110011): alu_src = 0. funct7 bit30 selects sub/sra. Any other funct7 → illegal.
- OP-IMM (0010011): alu_src = 1, imm = I-type sign-extended.
- Shift immediates (SLLI/SRLI/SRAI): imm = {27'b0, shamt}. The ALU shifts by the full B operand, so funct7 bits must not leak into imm. SLLI/SRLI require funct7 = 0; SRAI requires funct7 = 0100000; otherwise illegal.
- LUI: rs1_idx forced 0, alu_op add, alu_src 1, imm = {inst[31:12], 12'b0}.
- AUIPC: alu_op pc+B, alu_src 1, U-imm.
- JAL: alu_op pc+B, J-imm, jal = 1, reg_wen per rd. Link value is formed downstream.
- JALR: alu_op add, I-imm, jalr = 1. funct3 ≠ 0 → illegal.
- BRANCH: alu_op pc+B, B-imm, branch = 1, reg_wen = 0, funct3 passed through. funct3 010/011 → illegal.
- LOAD: alu_op add, I-imm, mem_ren = 1. STORE: alu_op add, S-imm, mem_wen = 1, reg_wen = 0.
- SYSTEM: inst = 0x00100073 → ebreak = 1, all enables 0.
- Any unlisted encoding → illegal = 1; reg_wen, mem_ren, mem_wen, branch, jal, jalr all 0; out_valid still asserted so the EXU can trap.
- Immediates: B and J immediates have bit 0 = 0. All immediates are sign-extended from inst[31] except shift amounts.

Test Plan:
- Reset then 0x00500093 (addi x1,x0,5), out_ready = 1 → one cycle later: out_valid = 1, rd 1, rs1 0, imm 0x5, alu_op 0000, alu_src 1, reg_wen 1.
- 0x4030D113 (srai x2,x1,3) → alu_op 0101, imm 0x00000003 (not 0x403), rs1 1, rd 2. 0x402081B3 (sub x3,x1,x2) → alu_op 1010, alu_src 0, rs2 2.
- Back-pressure: issue 0x00500093, hold out_ready = 0 for 3 cycles with 0x402081B3 on input → in_ready = 0, payload unchanged. Release → next cycle shows sub; exactly 2 bundles total, none lost or duplicated.
- Flush while out_valid = 1 and in_valid = 1 (0x00100073) → out_valid = 0 next cycle; the ebreak never appears; in_ready = 1 afterward.
- Illegal and boundary encodings:
  - 0xFFFFFFFF → out_illegal 1, reg_wen 0, out_valid 1.
  - 0x00000093 (addi x1,x0,0) with rd = x0 variant 0x00000013 → reg_wen 0.
  - 0xFE000EE3 (beq, imm −4) → imm 0xFFFFFFFC, branch 1.
- Assert rst mid-stream while out_valid = 1 and out_ready = 0 → next cycle out_valid = 0 and payload 0; a held input is not captured.
